layer_line_sequencer: RTL and testbench
=======================================

// Module: layer_line_sequencer
// PURPOSE
//   Per-layer line sequencer driving the layer_line_buffer write side. On each composer line_start
//   it swaps the double-buffer bank and optionally clears the new render bank. It then starts the
//   layer renderer for the next line and forwards its pixel writes until render_done.
//   Sits between the VERA-style layer renderer and its layer_line_buffer; flags render overruns.
// PARAMETERS
//   MAX_WIDTH   768  max pixels per line (line buffer capacity; idx 0..767)
//   CLR_DEFAULT 0    reset value of clear colour (8b, palette index 0 = transparent)
// PORTS
//   clk                  in   1   system clock; single clock domain
//   rst                  in   1   synchronous, active-high reset
//   layer_en             in   1   layer enable; 0 = no render/clear activity
//   clear_en             in   1   1 = clear render bank before rendering
//   clear_val            in   8   colour written during clear
//   line_width           in   10  pixels per line; values > MAX_WIDTH clamp to MAX_WIDTH
//   next_line_y          in   10  line number to render next; sampled at line_start
//   line_start           in   1   1-cycle pulse from composer: start of displayed line
//   render_start         out  1   1-cycle pulse to renderer: begin line render_line_y
//   render_line_y        out  10  latched next_line_y
//   render_done          in   1   1-cycle pulse from renderer: line complete
//   rnd_wr_idx           in   10  renderer pixel index
//   rnd_wr_data          in   8   renderer pixel data
//   rnd_wr_en            in   1   renderer write strobe
//   active_render_buffer out  1   to line buffer: bank being rendered
//   lb_wr_idx            out  10  to line buffer renderer_wr_idx
//   lb_wr_data           out  8   to line buffer renderer_wr_data
//   lb_wr_en             out  1   to line buffer renderer_wr_en
//   busy                 out  1   1 in CLEAR or RENDER
//   overrun              out  1   sticky; set on overrun, cleared only by rst
//   overrun_cnt          out  8   overrun count; saturates at 255
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; render_line_y 0.
//   FSM: IDLE, CLEAR, START, RENDER, DONE.
//     IDLE/DONE + line_start & layer_en:
//       toggle active_render_buffer; latch render_line_y <= next_line_y.
//       Go to CLEAR if clear_en & width!=0, else START.
//     line_start & !layer_en: bank still toggles; state -> IDLE.
//     CLEAR: clr_idx counts 0..width-1, one write per cycle: lb_wr_en=1, lb_wr_idx=clr_idx,
//       lb_wr_data=clear_val. Goes to START after idx width-1. Takes width cycles.
//     START: render_start=1 for exactly 1 cycle -> RENDER.
//     RENDER: lb_wr_* <= rnd_wr_* (registered, 1-cycle latency). render_done -> DONE.
//   Renderer writes outside RENDER are dropped (lb_wr_en=0).
//   Writes with rnd_wr_idx >= MAX_WIDTH are dropped.
//   All lb_wr_* outputs are registered. Write latency: clear = 1 cycle after state entry;
//   renderer = 1 cycle.
//   Overrun: line_start while in CLEAR, START or RENDER (and not render_done in the same cycle).
//     Sets overrun and increments overrun_cnt. The current line is aborted, and the new line is
//     handled exactly as a line_start from IDLE (bank toggle, latch, CLEAR/START).
//   render_done and line_start in the same cycle: the line counts complete, no overrun.
//   render_done outside RENDER: ignored.
//   layer_en deasserted mid-line: the current line finishes; no new line starts until layer_en=1.
//   Width arithmetic: eff_width = min(line_width, MAX_WIDTH), 10b. Clear counter is 10b, no wrap.
//   busy = state in {CLEAR, START, RENDER}.
// STRUCTURE
//   Shared package (vera_pkg): lseq_state_t enum {IDLE, CLEAR, START, RENDER, DONE};
//   LB_MAX_WIDTH=768; LB_IDX_W=10; PIX_W=8.
//   Sub-module: line_clear_engine (start, width, val -> idx/data/en, done), a counter plus
//   compare. The FSM and write-port mux stay in the top level.
// TESTING
//   1. rst mid-CLEAR at clr_idx 100 -> next cycle: state IDLE, lb_wr_en=0, all outputs 0.
//   2. line_width=320, clear_en=1, clear_val=0x00, line_start -> 320 writes idx 0..319 data 0;
//      render_start 1 cycle after the last clear write; bank bit toggled 0->1.
//   3. clear_en=0; renderer writes idx 5 data 0xAB in RENDER -> lb_wr idx 5 data 0xAB
//      exactly 1 cycle later; the same write in DONE -> lb_wr_en stays 0.
//   4. line_start during RENDER -> overrun=1, overrun_cnt=1, bank toggles, new render_start.
//      Same-cycle render_done+line_start -> overrun_cnt unchanged.
//   5. line_width=1000 -> exactly 768 clear writes (idx 0..767); rnd_wr_idx=800 dropped.
//   6. 300 overruns -> overrun_cnt saturates at 255. layer_en=0 at line_start -> bank toggles,
//      no render_start, no writes.

Source files
------------

// File: rtl/vera_pkg.sv
// Shared types and sizes for the layer line path (renderer -> sequencer -> line buffer).
package vera_pkg;

  localparam int LB_MAX_WIDTH = 768;
  localparam int LB_IDX_W     = 10;
  localparam int PIX_W        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    START  = 3'd2,
    RENDER = 3'd3,
    DONE   = 3'd4
  } lseq_state_t;

  function automatic logic [LB_IDX_W-1:0] clamp_width(input logic [LB_IDX_W-1:0] w,
                                                      input logic [LB_IDX_W-1:0] max_w);
    return (w > max_w) ? max_w : w;
  endfunction

endpackage

// File: rtl/line_clear_engine.sv
// Clear-pass index generator: loads on start, emits one index per step cycle until width-1.
// Combinational idx/en/done from state; width and colour are captured at start.
module line_clear_engine
  import vera_pkg::*;
#(
  parameter logic [PIX_W-1:0] CLR_DEFAULT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic [LB_IDX_W-1:0] width,
  input  logic [PIX_W-1:0]    val,
  output logic [LB_IDX_W-1:0] idx,
  output logic [PIX_W-1:0]    data,
  output logic                en,
  output logic                done
);

  logic [LB_IDX_W-1:0] last_idx;

  // start is only raised for a non-zero width, so width-1 never underflows
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      last_idx <= '0;
      data     <= CLR_DEFAULT;
    end else if (start) begin
      idx      <= '0;
      last_idx <= width - 10'd1;
      data     <= val;
    end else if (step && !done) begin
      idx <= idx + 10'd1;
    end
  end

  assign en   = step;
  assign done = (idx == last_idx);

endmodule

// File: rtl/layer_line_sequencer.sv
// Per-layer line sequencer: bank swap + optional clear + renderer kick, forwarding pixel writes.
// All line-buffer writes are registered (1-cycle latency); a line_start while busy aborts and flags overrun.
module layer_line_sequencer
  import vera_pkg::*;
#(
  parameter int               MAX_WIDTH   = LB_MAX_WIDTH,
  parameter logic [PIX_W-1:0] CLR_DEFAULT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                layer_en,
  input  logic                clear_en,
  input  logic [PIX_W-1:0]    clear_val,
  input  logic [LB_IDX_W-1:0] line_width,
  input  logic [LB_IDX_W-1:0] next_line_y,
  input  logic                line_start,
  output logic                render_start,
  output logic [LB_IDX_W-1:0] render_line_y,
  input  logic                render_done,
  input  logic [LB_IDX_W-1:0] rnd_wr_idx,
  input  logic [PIX_W-1:0]    rnd_wr_data,
  input  logic                rnd_wr_en,
  output logic                active_render_buffer,
  output logic [LB_IDX_W-1:0] lb_wr_idx,
  output logic [PIX_W-1:0]    lb_wr_data,
  output logic                lb_wr_en,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          overrun_cnt
);

  localparam logic [LB_IDX_W-1:0] MAX_W = LB_IDX_W'(MAX_WIDTH);

  lseq_state_t         state;
  logic [LB_IDX_W-1:0] eff_width;
  logic [LB_IDX_W-1:0] clr_idx;
  logic [PIX_W-1:0]    clr_data;
  logic                clr_en;
  logic                clr_done;
  logic                clr_start;
  logic                clr_step;
  logic                line_done;
  logic                ovr_hit;
  logic                take_line;
  logic                rnd_ok;

  assign eff_width = clamp_width(line_width, MAX_W);
  assign busy      = (state == CLEAR) || (state == START) || (state == RENDER);
  assign line_done = (state == RENDER) && render_done;
  assign ovr_hit   = line_start && busy && !line_done;
  assign take_line = line_start && layer_en;
  assign clr_start = take_line && clear_en && (eff_width != '0);
  assign clr_step  = (state == CLEAR) && !line_start;
  // Writes in a line_start cycle would land after the bank flip, so they are dropped
  assign rnd_ok    = (state == RENDER) && rnd_wr_en && (rnd_wr_idx < MAX_W) && !line_start;

  line_clear_engine #(
    .CLR_DEFAULT (CLR_DEFAULT)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .step  (clr_step),
    .width (eff_width),
    .val   (clear_val),
    .idx   (clr_idx),
    .data  (clr_data),
    .en    (clr_en),
    .done  (clr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      active_render_buffer <= 1'b0;
      render_line_y        <= '0;
      render_start         <= 1'b0;
      lb_wr_en             <= 1'b0;
      lb_wr_idx            <= '0;
      lb_wr_data           <= '0;
      overrun              <= 1'b0;
      overrun_cnt          <= '0;
    end else begin
      render_start <= (state == START) && !line_start;

      lb_wr_en <= 1'b0;
      if (clr_en) begin
        lb_wr_en   <= 1'b1;
        lb_wr_idx  <= clr_idx;
        lb_wr_data <= clr_data;
      end else if (rnd_ok) begin
        lb_wr_en   <= 1'b1;
        lb_wr_idx  <= rnd_wr_idx;
        lb_wr_data <= rnd_wr_data;
      end

      if (ovr_hit) begin
        overrun <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end

      if (line_start) begin
        active_render_buffer <= ~active_render_buffer;
        if (layer_en) begin
          render_line_y <= next_line_y;
          state         <= clr_start ? CLEAR : START;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          CLEAR:   if (clr_done) state <= START;
          START:   state <= RENDER;
          RENDER:  if (render_done) state <= DONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_line_sequencer.sv
// Scoreboard bench for layer_line_sequencer: expected line-buffer writes queued at stimulus time.
module tb_layer_line_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       layer_en;
  logic       clear_en;
  logic [7:0] clear_val;
  logic [9:0] line_width;
  logic [9:0] next_line_y;
  logic       line_start;
  logic       render_start;
  logic [9:0] render_line_y;
  logic       render_done;
  logic [9:0] rnd_wr_idx;
  logic [7:0] rnd_wr_data;
  logic       rnd_wr_en;
  logic       active_render_buffer;
  logic [9:0] lb_wr_idx;
  logic [7:0] lb_wr_data;
  logic       lb_wr_en;
  logic       busy;
  logic       overrun;
  logic [7:0] overrun_cnt;

  layer_line_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .layer_en             (layer_en),
    .clear_en             (clear_en),
    .clear_val            (clear_val),
    .line_width           (line_width),
    .next_line_y          (next_line_y),
    .line_start           (line_start),
    .render_start         (render_start),
    .render_line_y        (render_line_y),
    .render_done          (render_done),
    .rnd_wr_idx           (rnd_wr_idx),
    .rnd_wr_data          (rnd_wr_data),
    .rnd_wr_en            (rnd_wr_en),
    .active_render_buffer (active_render_buffer),
    .lb_wr_idx            (lb_wr_idx),
    .lb_wr_data           (lb_wr_data),
    .lb_wr_en             (lb_wr_en),
    .busy                 (busy),
    .overrun              (overrun),
    .overrun_cnt          (overrun_cnt)
  );

  always #5 clk = ~clk;

  logic [18:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rs_cnt = 0;
  int          rs_snap;
  logic        exp_bank = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [9:0] y);
    next_line_y = y;
    line_start  = 1'b1;
    exp_bank    = ~exp_bank;
    tick();
    line_start  = 1'b0;
  endtask

  task automatic push_clear(input int n, input logic [7:0] val);
    for (int i = 0; i < n; i++) sb.push_back({~exp_bank, 10'(i), val});
  endtask

  task automatic wait_rs(input string tag, input int exp);
    int n = 0;
    while (!render_start && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, n, exp);
  endtask

  task automatic finish_line();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
  endtask

  task automatic rnd_write(input logic [9:0] idx, input logic [7:0] dat);
    rnd_wr_idx  = idx;
    rnd_wr_data = dat;
    rnd_wr_en   = 1'b1;
    tick();
    rnd_wr_en   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_state"}, {busy, lb_wr_en, render_start, active_render_buffer, overrun}, 0);
    chk({tag, "_cnt"}, overrun_cnt, 0);
    chk({tag, "_idx"}, {lb_wr_idx, lb_wr_data}, 0);
    chk({tag, "_y"}, render_line_y, 0);
  endtask

  always @(negedge clk) begin
    if (lb_wr_en) begin
      if (sb.size() == 0) chk("wr_unexp", lb_wr_en, 0);
      else chk("wr", {active_render_buffer, lb_wr_idx, lb_wr_data}, sb.pop_front());
    end
    if (render_start) rs_cnt++;
  end

  initial begin
    rst = 1'b1; layer_en = 1'b1; clear_en = 1'b0; clear_val = 8'h00;
    line_width = 10'd320; next_line_y = '0; line_start = 1'b0; render_done = 1'b0;
    rnd_wr_idx = '0; rnd_wr_data = '0; rnd_wr_en = 1'b0;
    repeat (3) tick();
    chk_reset_state("rst0");
    rst = 1'b0;
    tick();

    // 320-wide clear followed by a render kick
    clear_en = 1'b1; clear_val = 8'h00;
    push_clear(320, 8'h00);
    start_line(10'd7);
    chk("bank_first", active_render_buffer, 1);
    chk("line_y", render_line_y, 7);
    chk("busy_clear", busy, 1);
    wait_rs("rs_after_clr320", 321);
    chk("clr320_drained", sb.size(), 0);

    // renderer write forwarded one cycle later; dropped outside RENDER
    sb.push_back({exp_bank, 10'd5, 8'hAB});
    rnd_write(10'd5, 8'hAB);
    chk("rnd_wr_lat", {lb_wr_en, lb_wr_idx, lb_wr_data}, {1'b1, 10'd5, 8'hAB});
    finish_line();
    chk("busy_done", busy, 0);
    rnd_write(10'd5, 8'hAB);
    chk("rnd_wr_in_done", lb_wr_en, 0);

    // overrun during RENDER, then coincident done+start
    clear_en = 1'b0;
    start_line(10'd11);
    wait_rs("rs_noclr", 1);
    start_line(10'd12);
    chk("ovr_flag", overrun, 1);
    chk("ovr_cnt1", overrun_cnt, 1);
    chk("ovr_bank", active_render_buffer, exp_bank);
    chk("ovr_y", render_line_y, 12);
    wait_rs("rs_after_ovr", 1);
    render_done = 1'b1; line_start = 1'b1; next_line_y = 10'd13; exp_bank = ~exp_bank;
    tick();
    render_done = 1'b0; line_start = 1'b0;
    chk("done_start_cnt", overrun_cnt, 1);
    chk("done_start_bank", active_render_buffer, exp_bank);
    wait_rs("rs_done_start", 1);
    finish_line();

    // oversize width clamps to 768; out-of-range renderer index dropped
    line_width = 10'd1000; clear_en = 1'b1; clear_val = 8'h5A;
    push_clear(768, 8'h5A);
    start_line(10'd20);
    wait_rs("rs_after_clr768", 769);
    chk("clr768_drained", sb.size(), 0);
    rnd_write(10'd800, 8'h11);
    chk("rnd_wr_800", lb_wr_en, 0);
    sb.push_back({exp_bank, 10'd767, 8'h22});
    rnd_write(10'd767, 8'h22);
    chk("rnd_wr_767", {lb_wr_en, lb_wr_idx, lb_wr_data}, {1'b1, 10'd767, 8'h22});
    finish_line();

    // 300 back-to-back overruns saturate the counter
    clear_en = 1'b0;
    start_line(10'd30);
    wait_rs("rs_pre_sat", 1);
    line_start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      exp_bank = ~exp_bank;
      tick();
    end
    line_start = 1'b0;
    chk("ovr_sat", overrun_cnt, 255);
    chk("ovr_sat_bank", active_render_buffer, exp_bank);
    wait_rs("rs_post_sat", 1);
    finish_line();

    // layer disabled: bank flips, nothing else happens
    layer_en = 1'b0;
    rs_snap  = rs_cnt;
    start_line(10'd40);
    chk("dis_bank", active_render_buffer, exp_bank);
    repeat (5) tick();
    chk("dis_busy", busy, 0);
    chk("dis_no_rs", rs_cnt, rs_snap);
    chk("dis_sb_empty", sb.size(), 0);
    layer_en = 1'b1;

    // reset while the clear counter sits at 100
    line_width = 10'd320; clear_en = 1'b1; clear_val = 8'h33;
    push_clear(100, 8'h33);
    start_line(10'd50);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    exp_bank = 1'b0;
    chk_reset_state("rst_mid_clr");
    chk("rst_sb_empty", sb.size(), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_stays_idle", {busy, lb_wr_en}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
